// File: rtl/mw_writeback.sv
// Memory-to-writeback pipeline register with the GRF write-data mux and the retired-instruction counter.
// Define MW_LOAD_EXT_EN to build in lb/lbu/lh/lhu extension; without it, memory results are passed through as lw.
module mw_writeback (
  input  logic        clk,
  input  logic        reset,
  input  logic        ValidM,
  input  logic        FlushM,
  input  logic        RegWriteM2,
  input  logic [1:0]  MemtoRegM2,
  input  logic [31:0] RDM,
  input  logic [31:0] ALUoutM2,
  input  logic [31:0] PC_4M2,
  input  logic [31:0] ext_immM2,
  input  logic [1:0]  TnewM2,
  input  logic [4:0]  AwriteM2,
  input  logic [2:0]  LoadTypeM,
  output logic        RegWriteW,
  output logic [4:0]  AwriteW,
  output logic [31:0] ResultW,
  output logic [1:0]  TnewW,
  output logic [31:0] PC_4W,
  output logic        ValidW,
  output logic [31:0] InstrCountW
);

  logic        valid_reg;
  logic        reg_write_reg;
  logic [1:0]  mem_to_reg_reg;
  logic [31:0] rd_reg;
  logic [31:0] alu_out_reg;
  logic [31:0] pc4_reg;
  logic [31:0] ext_imm_reg;
  logic [4:0]  awrite_reg;
  logic [1:0]  tnew_reg;
  logic [31:0] count_reg;
  logic [31:0] mem_data;

`ifdef MW_LOAD_EXT_EN
  logic [2:0]  load_type_reg;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
`else
  logic        unused_load_type;
  assign unused_load_type = ^LoadTypeM;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_reg      <= 1'b0;
      reg_write_reg  <= 1'b0;
      mem_to_reg_reg <= 2'd0;
      rd_reg         <= 32'd0;
      alu_out_reg    <= 32'd0;
      pc4_reg        <= 32'd0;
      ext_imm_reg    <= 32'd0;
      awrite_reg     <= 5'd0;
      tnew_reg       <= 2'd0;
      count_reg      <= 32'd0;
`ifdef MW_LOAD_EXT_EN
      load_type_reg  <= 3'd0;
`endif
    end else begin
      if (FlushM) begin
        valid_reg      <= 1'b0;
        reg_write_reg  <= 1'b0;
        mem_to_reg_reg <= 2'd0;
        rd_reg         <= 32'd0;
        alu_out_reg    <= 32'd0;
        pc4_reg        <= 32'd0;
        ext_imm_reg    <= 32'd0;
        awrite_reg     <= 5'd0;
        tnew_reg       <= 2'd0;
`ifdef MW_LOAD_EXT_EN
        load_type_reg  <= 3'd0;
`endif
      end else begin
        valid_reg      <= ValidM;
        reg_write_reg  <= RegWriteM2;
        mem_to_reg_reg <= MemtoRegM2;
        rd_reg         <= RDM;
        alu_out_reg    <= ALUoutM2;
        pc4_reg        <= PC_4M2;
        ext_imm_reg    <= ext_immM2;
        awrite_reg     <= AwriteM2;
        tnew_reg       <= (TnewM2 == 2'd0) ? 2'd0 : TnewM2 - 2'd1;
`ifdef MW_LOAD_EXT_EN
        load_type_reg  <= LoadTypeM;
`endif
      end
      if (ValidM && !FlushM)
        count_reg <= count_reg + 32'd1;
    end
  end

  // Misaligned halves are not faulted: only ALUout[1] picks the half.
  always_comb begin
    mem_data = rd_reg;
`ifdef MW_LOAD_EXT_EN
    byte_sel = rd_reg[7:0];
    case (alu_out_reg[1:0])
      2'd0:    byte_sel = rd_reg[7:0];
      2'd1:    byte_sel = rd_reg[15:8];
      2'd2:    byte_sel = rd_reg[23:16];
      default: byte_sel = rd_reg[31:24];
    endcase
    half_sel = alu_out_reg[1] ? rd_reg[31:16] : rd_reg[15:0];
    case (load_type_reg)
      3'b001:  mem_data = {{24{byte_sel[7]}}, byte_sel};
      3'b010:  mem_data = {24'd0, byte_sel};
      3'b011:  mem_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  mem_data = {16'd0, half_sel};
      default: mem_data = rd_reg;
    endcase
`endif
  end

  always_comb begin
    ResultW = alu_out_reg;
    case (mem_to_reg_reg)
      2'b00:   ResultW = alu_out_reg;
      2'b01:   ResultW = mem_data;
      2'b10:   ResultW = pc4_reg + 32'd4;
      default: ResultW = ext_imm_reg;
    endcase
  end

  assign RegWriteW   = reg_write_reg && valid_reg && (awrite_reg != 5'd0);
  assign AwriteW     = awrite_reg;
  assign TnewW       = tnew_reg;
  assign PC_4W       = pc4_reg;
  assign ValidW      = valid_reg;
  assign InstrCountW = count_reg;

endmodule
